// File: rtl/seg7_pkg.sv
// seg7_pkg: shared glyph table, DEPTH bounds and parameter defaults for the switch history display
package seg7_pkg;
    localparam int DEPTH_MIN    = 2;
    localparam int DEPTH_MAX    = 8;
    localparam int DEF_DEPTH    = 8;
    localparam int DEF_DEB_CYC  = 4;
    localparam int DEF_SCAN_DIV = 16;
    localparam int DEF_INVERT   = 1;
    // segments {a,b,c,d,e,f,g}; element n is the glyph for hex digit n
    localparam logic [15:0][6:0] GLYPH = {
        7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
        7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
    };
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational hex digit to seven-segment glyph
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    assign seg = GLYPH[hex];
endmodule

// File: rtl/sw_history_display.sv
// sw_history_display: debounced switch history shown as hex digits on a scanned seven-segment display
module sw_history_display
    import seg7_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int DEB_CYC  = DEF_DEB_CYC,
    parameter int SCAN_DIV = DEF_SCAN_DIV,
    parameter int INVERT   = DEF_INVERT
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] switch,
    input  logic       clr,
    output logic [7:0] num_csn,
    output logic [6:0] num_a_g,
    output logic [3:0] led
);
    // out-of-range DEPTH is clamped to the legal window
    localparam int D = DEPTH < DEPTH_MIN ? DEPTH_MIN : (DEPTH > DEPTH_MAX ? DEPTH_MAX : DEPTH);
    localparam logic [7:0] MASK = 8'((9'd1 << D) - 9'd1);

    logic [3:0]  s1, s2, cand, cand_q, last;
    logic [15:0] cnt, scan_cnt;
    logic [16:0] stable_n;
    logic        accept;
    logic [3:0]  ent [8];
    logic [7:0]  valid;
    logic [2:0]  idx;
    logic [6:0]  glyph;

    // candidate value and its stable-cycle count including the current cycle
    always_comb begin
        cand     = INVERT != 0 ? ~s2 : s2;
        stable_n = cand == cand_q ? {1'b0, cnt} + 17'd1 : 17'd1;
        accept   = stable_n >= 17'(DEB_CYC) && cand != last;
    end

    // synchroniser and saturating stability counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1     <= '0;
            s2     <= '0;
            cand_q <= '0;
            cnt    <= '0;
        end else begin
            s1     <= switch;
            s2     <= s1;
            cand_q <= cand;
            cnt    <= stable_n >= 17'(DEB_CYC) ? 16'(DEB_CYC) : stable_n[15:0];
        end
    end

    // history shift register; clr drops any accept on the same edge
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < 8; k++) ent[k] <= '0;
            valid <= '0;
            last  <= '0;
        end else if (clr) begin
            for (int k = 0; k < 8; k++) ent[k] <= '0;
            valid <= '0;
            last  <= cand;
        end else if (accept) begin
            ent[0] <= cand;
            for (int k = 1; k < 8; k++) ent[k] <= k < D ? ent[k-1] : 4'h0;
            valid <= {valid[6:0], 1'b1} & MASK;
            last  <= cand;
        end
    end

    // digit scan: index advances once every SCAN_DIV cycles
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == 16'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= idx == 3'(D - 1) ? 3'd0 : idx + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + 16'd1;
        end
    end

    seg7_decode u_dec (
        .hex(ent[idx]),
        .seg(glyph)
    );

    // registered outputs; enable and segments come from the same index
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            num_csn <= 8'hFF;
            num_a_g <= 7'h00;
            led     <= 4'h0;
        end else begin
            num_csn <= ~(8'd1 << idx);
            num_a_g <= valid[idx] ? glyph : 7'h00;
            led     <= valid[1] ? ent[1] : 4'h0;
        end
    end
endmodule

// File: tb/tb_sw_history_display.sv
// tb_sw_history_display: directed self-checking bench for sw_history_display
module tb_sw_history_display;
    logic       clk = 0;
    logic       resetn = 0;
    logic [3:0] switch = 4'hF;
    logic       clr = 0;
    logic [7:0] csn8, csn4;
    logic [6:0] seg8, seg4;
    logic [3:0] led8, led4;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sw_history_display #(.DEPTH(8), .DEB_CYC(4), .SCAN_DIV(2), .INVERT(1)) u8 (
        .clk(clk), .resetn(resetn), .switch(switch), .clr(clr),
        .num_csn(csn8), .num_a_g(seg8), .led(led8)
    );

    sw_history_display #(.DEPTH(4), .DEB_CYC(4), .SCAN_DIV(1), .INVERT(1)) u4 (
        .clk(clk), .resetn(resetn), .switch(switch), .clr(clr),
        .num_csn(csn4), .num_a_g(seg4), .led(led4)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic read_digit(input bit sel, input int k, output logic [6:0] seg);
        logic [7:0] want;
        bit found;
        want  = ~(8'h01 << k);
        found = 0;
        seg   = 7'h7F;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if ((sel ? csn4 : csn8) == want) begin
                seg   = sel ? seg4 : seg8;
                found = 1;
            end
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL digit%0d_timeout: observed none expected enable", k);
        end
    endtask

    task automatic settle(input logic [3:0] v);
        switch = v;
        repeat (10) @(negedge clk);
    endtask

    logic [6:0] g;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_csn", csn8, 8'hFF);
        chk("rst_seg", {1'b0, seg8}, 8'h00);
        chk("rst_led", {4'h0, led8}, 8'h00);
        chk("rst_csn4", csn4, 8'hFF);

        resetn = 1;
        @(negedge clk);
        chk("rel_csn", csn8, 8'hFE);
        chk("rel_seg", {1'b0, seg8}, 8'h00);
        repeat (10) @(negedge clk);
        chk("rel_nopush", u8.valid, 8'h00);

        // F->8: value 7 lands exactly 6 edges later
        switch = 4'h8;
        repeat (5) @(negedge clk);
        chk("deb_early", u8.valid, 8'h00);
        @(negedge clk);
        chk("deb_valid", u8.valid, 8'h01);
        chk("deb_ent0", {4'h0, u8.ent[0]}, 8'h07);

        // 3-cycle glitch to 9 must not push
        switch = 4'h9;
        repeat (3) @(negedge clk);
        settle(4'h8);
        chk("glitch_valid", u8.valid, 8'h01);
        chk("glitch_ent0", {4'h0, u8.ent[0]}, 8'h07);

        settle(4'h9);
        settle(4'hE);
        settle(4'h2);
        settle(4'h0);
        chk("hist_led", {4'h0, led8}, 8'h0D);
        read_digit(0, 0, g); chk("hist_d0", {1'b0, g}, 8'h47);
        read_digit(0, 1, g); chk("hist_d1", {1'b0, g}, 8'h3D);
        read_digit(0, 2, g); chk("hist_d2", {1'b0, g}, 8'h30);
        read_digit(0, 3, g); chk("hist_d3", {1'b0, g}, 8'h5F);
        read_digit(0, 4, g); chk("hist_d4", {1'b0, g}, 8'h70);
        read_digit(0, 5, g); chk("hist_d5", {1'b0, g}, 8'h00);

        // DEPTH=4 copy: oldest (7) dropped, scan wraps E,D,B,7
        chk("wrap_led", {4'h0, led4}, 8'h0D);
        read_digit(1, 0, g); chk("wrap_d0", {1'b0, g}, 8'h47);
        read_digit(1, 3, g); chk("wrap_d3", {1'b0, g}, 8'h5F);
        read_digit(1, 0, g);
        chk("wrap_seq0", csn4, 8'hFE);
        for (int i = 1; i < 9; i++) begin
            @(negedge clk);
            case (i % 4)
                1: chk("wrap_seq", csn4, 8'hFD);
                2: chk("wrap_seq", csn4, 8'hFB);
                3: chk("wrap_seq", csn4, 8'hF7);
                default: chk("wrap_seq", csn4, 8'hFE);
            endcase
        end

        // clr on the accept edge of value A
        switch = 4'h5;
        repeat (5) @(negedge clk);
        clr = 1;
        @(negedge clk);
        clr = 0;
        repeat (20) @(negedge clk);
        chk("clr_valid", u8.valid, 8'h00);
        chk("clr_led", {4'h0, led8}, 8'h00);
        read_digit(0, 0, g); chk("clr_d0", {1'b0, g}, 8'h00);
        read_digit(0, 1, g); chk("clr_d1", {1'b0, g}, 8'h00);
        chk("clr_valid4", u4.valid, 8'h00);

        // mid-operation reset
        settle(4'h3);
        settle(4'h4);
        chk("pre_led", {4'h0, led8}, 8'h0C);
        @(negedge clk);
        #2 resetn = 0;
        #1;
        chk("mrst_csn", csn8, 8'hFF);
        chk("mrst_seg", {1'b0, seg8}, 8'h00);
        chk("mrst_led", {4'h0, led8}, 8'h00);
        chk("mrst_valid", u8.valid, 8'h00);
        chk("mrst_csn4", csn4, 8'hFF);
        @(negedge clk);
        resetn = 1;
        @(negedge clk);
        chk("mrst_rel_csn", csn8, 8'hFE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sw_history_display.md
SW_HISTORY_DISPLAY -- requirements
Module: sw_history_display

Interface
REQ-001 SHALL have parameter DEPTH, default 8: history entries shown, one per digit, legal 2..8.
REQ-002 SHALL have parameter DEB_CYC, default 4: consecutive stable cycles needed before a switch value is accepted, legal 1..65535.
REQ-003 SHALL have parameter SCAN_DIV, default 16: clock cycles each digit stays enabled, legal 1..65535.
REQ-004 SHALL have parameter INVERT, default 1: 1 stores ~switch, 0 stores switch.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-006 SHALL have port resetn, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port switch, input, 4 bits: asynchronous switch bank.
REQ-008 SHALL have port clr, input, 1 bit: synchronous history clear, active-high.
REQ-009 SHALL have port num_csn, output, 8 bits: digit enables, active-low, bit k drives digit k.
REQ-010 SHALL have port num_a_g, output, 7 bits: segments {a,b,c,d,e,f,g}, active-high.
REQ-011 SHALL have port led, output, 4 bits: previous accepted value.

Function
REQ-012 SHALL pass switch through a 2-flop synchroniser before any other use.
REQ-013 SHALL form the candidate value from the synchronised switch, inverted when INVERT=1.
REQ-014 SHALL keep a stability counter that restarts whenever the candidate changes.
REQ-015 SHALL accept the candidate once it has been stable for DEB_CYC cycles and differs from the last accepted value; end-to-end latency is 2+DEB_CYC edges after the input change.
REQ-016 SHALL make at most one accept per stable period; a candidate equal to the last accepted value SHALL NOT push.
REQ-017 SHALL on accept shift the history: entry0 <= new value, entry k <= entry k-1, the oldest entry is dropped; valid bits shift the same way with valid0 <= 1.
REQ-018 SHALL when clr=1 clear all entries and valid bits and load the current candidate as last accepted value; clr wins over a simultaneous accept, and the accept is discarded, not deferred.
REQ-019 SHALL drive led = entry1 when valid1=1, else 4'h0.
REQ-020 SHALL scan digit index 0..DEPTH-1 and wrap to 0, advancing every SCAN_DIV cycles.
REQ-021 SHALL drive num_csn with exactly one zero, at the bit equal to the scan index; bits DEPTH..7 are never zero.
REQ-022 SHALL drive num_a_g with the hex glyph of the scanned entry when it is valid, else 7'b0000000 (blank).
REQ-023 SHALL use glyphs: 0=7E,1=30,2=6D,3=79,4=33,5=5B,6=5F,7=70,8=7F,9=7B,A=77,b=1F,C=4E,d=3D,E=4F,F=47 (hex).
REQ-024 SHALL register num_csn, num_a_g and led; segments and enable change on the same edge with no glitch cycle.
REQ-025 SHALL reflect a history update on num_a_g no later than the first scan slot of the affected digit that starts after the update edge.

Reset
REQ-026 SHALL while resetn=0 force num_csn=8'hFF, num_a_g=7'h00, led=4'h0, all entries and valid bits 0, last accepted value 4'h0, synchroniser flops 0, stability and scan counters 0, scan index 0.
REQ-027 SHALL after reset release enable digit 0 on the first rising edge, blank, because no entry is valid yet.
REQ-028 SHALL on reset assertion mid-debounce or mid-scan abandon all progress with no partial push.

Structure
REQ-029 SHALL keep the glyph table constants, the DEPTH legal bounds and the parameter defaults in a shared package, seg7_pkg.
REQ-030 SHALL place the combinational hex-to-glyph decode in the sub-module seg7_decode; everything else stays in sw_history_display.

Verification
REQ-031 SHALL cover reset: resetn=0 with switch=F -> num_csn=FF, num_a_g=00, led=0; after release digit 0 is enabled and blank, and no push occurs because ~F=0 equals the reset value.
REQ-032 SHALL cover debounce, with DEB_CYC=4: switch F->8 held -> entry0=7 exactly 6 edges later; a 3-cycle glitch to 9 and back -> no push.
REQ-033 SHALL cover history: sequence 8,9,E,2,0 (values 7,6,1,D,F) -> entries 0..4 = F,D,1,6,7, led=D, digit 0 glyph 47, digit 1 glyph 3D.
REQ-034 SHALL cover wrap, with DEPTH=4: five distinct accepts -> oldest dropped, num_csn cycles E,D,B,7 then repeats, bits 7..4 stay 1.
REQ-035 SHALL cover clr: clr on the accept edge -> all digits blank, led=0, and no later push of that value.
REQ-036 SHALL cover mid-operation reset: resetn pulsed low during a scan -> outputs at once equal the REQ-026 values, history empty.
